// File: rtl/bist_pkg.sv
// -----------------------------------------------------------------------------
// bist_pkg
// Shared definitions for the BIST stimulus/response controller:
//   - bist_state_e    : controller FSM states (IDLE, RUN, DONE)
//   - BIST_MISR_POLY_DEF / BIST_MISR_SEED_DEF : default MISR feedback and seed
//   - misr_next()     : one MISR step, width-generic up to 64 bits
// -----------------------------------------------------------------------------
package bist_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } bist_state_e;

  // x^25 + x^3 + 1
  localparam logic [24:0] BIST_MISR_POLY_DEF = 25'h0000009;
  localparam logic [24:0] BIST_MISR_SEED_DEF = 25'h0000000;

  // One MISR step on a w-bit register carried in the low bits of 64-bit
  // vectors: shift left, fold the dropped MSB back through poly, xor in din.
  // The result is masked to w bits; a shift by 64 yields 0, so the mask
  // also covers w == 64.
  function automatic logic [63:0] misr_next(
    input logic [63:0] sig,
    input logic [63:0] poly,
    input logic [63:0] din,
    input logic [6:0]  w
  );
    logic [63:0] shifted;
    logic [63:0] fb;
    logic [63:0] mask;
    logic [6:0]  msb_idx;
    msb_idx = w - 7'd1;
    shifted = {sig[62:0], 1'b0};
    fb      = sig[msb_idx[5:0]] ? poly : 64'd0;
    mask    = (64'd1 << w) - 64'd1;
    return (shifted ^ fb ^ din) & mask;
  endfunction

endpackage

// File: rtl/bist_misr.sv
// -----------------------------------------------------------------------------
// bist_misr
// Multiple-input signature register of width W.
// Ports:
//   clk  in  1  rising-edge clock
//   rst  in  1  synchronous active-high reset (loads SEED)
//   clr  in  1  synchronous reload of SEED (start of a run)
//   en   in  1  absorb din this edge
//   din  in  W  parallel data input (registered CUT response)
//   sig  out W  current signature
// clr has priority over en.
// -----------------------------------------------------------------------------
module bist_misr
  import bist_pkg::*;
#(
  parameter int             W    = 25,
  parameter logic [W-1:0]   POLY = BIST_MISR_POLY_DEF,
  parameter logic [W-1:0]   SEED = BIST_MISR_SEED_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] din,
  output logic [W-1:0] sig
);

  logic [W-1:0] sig_q;
  logic [W-1:0] sig_d;
  logic [63:0]  sig_w;
  logic [63:0]  poly_w;
  logic [63:0]  din_w;
  logic [63:0]  nxt_w;
  logic         unused_nxt_s;

  // Next-signature selection: reload, absorb, or hold.
  always_comb begin
    sig_w  = 64'd0;
    poly_w = 64'd0;
    din_w  = 64'd0;
    sig_w[W-1:0]  = sig_q;
    poly_w[W-1:0] = POLY;
    din_w[W-1:0]  = din;
    nxt_w = misr_next(sig_w, poly_w, din_w, 7'(W));
    if (clr) begin
      sig_d = SEED;
    end else if (en) begin
      sig_d = nxt_w[W-1:0];
    end else begin
      sig_d = sig_q;
    end
  end

  // Upper bits of the 64-bit step result are always zero.
  assign unused_nxt_s = ^nxt_w;

  // Signature register.
  always_ff @(posedge clk) begin
    if (rst) begin
      sig_q <= SEED;
    end else begin
      sig_q <= sig_d;
    end
  end

  assign sig = sig_q;

endmodule

// File: rtl/bist_stim_resp_ctrl.sv
// -----------------------------------------------------------------------------
// bist_stim_resp_ctrl
// Exhaustive-pattern BIST controller for a combinational CUT. Issues every
// STIM_W-bit pattern, registers each response into resp_q and compacts it in
// a MISR (bist_misr). One run = PAT_CNT issue cycles + 1 drain cycle.
// Ports:
//   clk        in  1       rising-edge clock
//   rst        in  1       synchronous active-high reset
//   start      in  1       run request, honoured in IDLE and DONE only
//   stim       out STIM_W  registered pattern to CUT inputs
//   resp       in  RESP_W  CUT outputs (combinational from stim)
//   busy       out 1       high while running
//   done       out 1       high in DONE (level)
//   signature  out RESP_W  MISR contents
//   pass       out 1       signature == GOLDEN, valid while done
// Optional build macro: BIST_GOLDEN_CMP_EN compiles in the golden-signature
// comparator; without it pass is constant 0 and GOLDEN is unused.
// -----------------------------------------------------------------------------
module bist_stim_resp_ctrl
  import bist_pkg::*;
#(
  parameter int                STIM_W    = 5,
  parameter int                RESP_W    = 25,
  parameter logic [RESP_W-1:0] MISR_POLY = BIST_MISR_POLY_DEF,
  parameter logic [RESP_W-1:0] MISR_SEED = BIST_MISR_SEED_DEF,
  parameter logic [RESP_W-1:0] GOLDEN    = 25'h0000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [STIM_W-1:0] stim,
  input  logic [RESP_W-1:0] resp,
  output logic              busy,
  output logic              done,
  output logic [RESP_W-1:0] signature,
  output logic              pass
);

  localparam logic [STIM_W-1:0] CNT_MAX = {STIM_W{1'b1}};
  localparam logic [STIM_W-1:0] CNT_ONE = {{(STIM_W-1){1'b0}}, 1'b1};

  bist_state_e       state_q, state_d;
  logic [STIM_W-1:0] cnt_q,   cnt_d;
  logic [STIM_W-1:0] stim_q,  stim_d;
  logic [RESP_W-1:0] resp_q,  resp_d;
  logic              drain_q, drain_d;
  logic              busy_q,  busy_d;
  logic              done_q,  done_d;
  logic              start_run_s;
  logic              misr_clr_s;
  logic              misr_en_s;

  assign start_run_s = start && ((state_q == IDLE) || (state_q == DONE));

  // FSM next state, pattern counter, response capture and MISR control.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    stim_d     = stim_q;
    resp_d     = resp_q;
    drain_d    = drain_q;
    misr_clr_s = 1'b0;
    misr_en_s  = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (start_run_s) begin
          state_d    = RUN;
          cnt_d      = {STIM_W{1'b0}};
          stim_d     = {STIM_W{1'b0}};
          drain_d    = 1'b0;
          misr_clr_s = 1'b1;
        end else begin
          state_d = state_q;
        end
      end
      RUN: begin
        // resp_q is not meaningful until the first RUN edge has captured
        // pattern 0, so the MISR skips that edge (cnt_q == 0, no drain).
        misr_en_s = (cnt_q != {STIM_W{1'b0}}) || drain_q;
        if (drain_q) begin
          state_d = DONE;
          drain_d = 1'b0;
          stim_d  = {STIM_W{1'b0}};
        end else begin
          resp_d = resp;
          cnt_d  = cnt_q + CNT_ONE;
          // Wraps to 0 after the last pattern, which also returns stim to 0.
          stim_d = cnt_q + CNT_ONE;
          if (cnt_q == CNT_MAX) begin
            drain_d = 1'b1;
          end else begin
            drain_d = 1'b0;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  // Controller state and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= {STIM_W{1'b0}};
      stim_q  <= {STIM_W{1'b0}};
      resp_q  <= {RESP_W{1'b0}};
      drain_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      stim_q  <= stim_d;
      resp_q  <= resp_d;
      drain_q <= drain_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  bist_misr #(
    .W    (RESP_W),
    .POLY (MISR_POLY),
    .SEED (MISR_SEED)
  ) u_misr (
    .clk (clk),
    .rst (rst),
    .clr (misr_clr_s),
    .en  (misr_en_s),
    .din (resp_q),
    .sig (signature)
  );

`ifdef BIST_GOLDEN_CMP_EN
  logic        pass_q, pass_d;
  logic [63:0] sig_w, poly_w, din_w, gold_w, nxt_w;

  // Golden compare against the signature the MISR takes at the DONE-entry
  // edge, so pass is valid in the same cycle as done.
  always_comb begin
    sig_w  = 64'd0;
    poly_w = 64'd0;
    din_w  = 64'd0;
    gold_w = 64'd0;
    sig_w[RESP_W-1:0]  = signature;
    poly_w[RESP_W-1:0] = MISR_POLY;
    din_w[RESP_W-1:0]  = resp_q;
    gold_w[RESP_W-1:0] = GOLDEN;
    nxt_w = misr_next(sig_w, poly_w, din_w, 7'(RESP_W));
    if (start_run_s) begin
      pass_d = 1'b0;
    end else if ((state_q == RUN) && drain_q) begin
      pass_d = (nxt_w == gold_w);
    end else begin
      pass_d = pass_q;
    end
  end

  // Pass flag register.
  always_ff @(posedge clk) begin
    if (rst) begin
      pass_q <= 1'b0;
    end else begin
      pass_q <= pass_d;
    end
  end

  assign pass = pass_q;
`else
  logic unused_golden_s;
  assign unused_golden_s = ^GOLDEN;
  assign pass = 1'b0;
`endif

  assign stim = stim_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule
